// File: rtl/flash_read_arbiter.sv
// Shares one Avalon-MM flash read port between two read masters: round-robin
// grant, a single outstanding read, data routed to the owner, readdatavalid timeout.
module flash_read_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              m0_read,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_timeout,
  input  logic              m1_read,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_timeout,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [DATA_W-1:0] flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic              owner,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              ptr_r;
  logic              owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        be_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;
  logic              rdv0_r;
  logic              rdv1_r;
  logic              to0_r;
  logic              to1_r;

  logic              req_any_s;
  logic              grant_s;
  logic              accept_s;
  logic              data_done_s;
  logic              tmo_s;

  // Arbitration: a lone requester wins, a tie goes to the priority pointer
  always_comb begin
    req_any_s = m0_read | m1_read;
    if (m0_read && m1_read) begin
      grant_s = ptr_r;
    end else if (m1_read) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Transaction events; valid wins over timeout in the final wait cycle
  always_comb begin
    accept_s    = (state_r == ST_ISSUE) && !flash_mem_waitrequest;
    data_done_s = (state_r == ST_WAIT) && flash_mem_readdatavalid;
    tmo_s       = (state_r == ST_WAIT) && !flash_mem_readdatavalid && (cnt_r == CNT_LAST);
  end

  // State register
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (accept_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (data_done_s || tmo_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Command-side outputs; the owner's waitrequest follows the flash stall
  always_comb begin
    flash_mem_read = (state_r == ST_ISSUE);
    busy           = (state_r != ST_IDLE);
    m0_waitrequest = !(flash_mem_read && !owner_r && !flash_mem_waitrequest);
    m1_waitrequest = !(flash_mem_read && owner_r && !flash_mem_waitrequest);
  end

  // Latch the winner's command at grant time
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      be_r    <= 4'b0000;
    end else if ((state_r == ST_IDLE) && req_any_s) begin
      owner_r <= grant_s;
      addr_r  <= grant_s ? m1_address : m0_address;
      be_r    <= grant_s ? m1_byteenable : m0_byteenable;
    end else begin
      owner_r <= owner_r;
      addr_r  <= addr_r;
      be_r    <= be_r;
    end
  end

  // Priority pointer flips away from the master that just completed
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (data_done_s || tmo_s) begin
      ptr_r <= ~owner_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Wait-cycle counter, cleared when flash accepts the command
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Per-master read data, held between reads
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_r <= {DATA_W{1'b0}};
      rdata1_r <= {DATA_W{1'b0}};
    end else if (data_done_s) begin
      if (owner_r) begin
        rdata0_r <= rdata0_r;
        rdata1_r <= flash_mem_readdata;
      end else begin
        rdata0_r <= flash_mem_readdata;
        rdata1_r <= rdata1_r;
      end
    end else begin
      rdata0_r <= rdata0_r;
      rdata1_r <= rdata1_r;
    end
  end

  // One-cycle completion pulses routed to the owner
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rdv0_r <= 1'b0;
      rdv1_r <= 1'b0;
      to0_r  <= 1'b0;
      to1_r  <= 1'b0;
    end else begin
      rdv0_r <= data_done_s && !owner_r;
      rdv1_r <= data_done_s && owner_r;
      to0_r  <= tmo_s && !owner_r;
      to1_r  <= tmo_s && owner_r;
    end
  end

  assign flash_mem_address    = addr_r;
  assign flash_mem_byteenable = be_r;
  assign owner                = owner_r;
  assign m0_readdata          = rdata0_r;
  assign m1_readdata          = rdata1_r;
  assign m0_readdatavalid     = rdv0_r;
  assign m1_readdatavalid     = rdv1_r;
  assign m0_timeout           = to0_r;
  assign m1_timeout           = to1_r;

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single Avalon-MM flash read port between two read masters.
  - Master 0: audio sample fetcher.
  - Master 1: second client, e.g. a display/LED pattern reader.
- Round-robin arbitration, one outstanding read at a time.
- Routes readdata back to the owning master; a timeout recovers from a lost readdatavalid.
- Sits between the requesters and the flash controller, all in the clk_50 domain.

Parameters:
ADDR_W, 23, flash word address width
DATA_W, 32, flash data width
TIMEOUT, 1024, max clk_50 cycles waiting for readdatavalid after command acceptance (>=2)

Ports:
clk_50  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m0_read  in  1  master 0 read request, held until m0_waitrequest low
m0_address  in  ADDR_W  master 0 address
m0_byteenable  in  4  master 0 byteenable
m0_waitrequest  out  1  low only in the cycle flash accepts master 0's command
m0_readdata  out  DATA_W  registered read data for master 0
m0_readdatavalid  out  1  one-cycle data-valid pulse
m0_timeout  out  1  one-cycle pulse, read abandoned
m1_read, m1_address, m1_byteenable, m1_waitrequest, m1_readdata, m1_readdatavalid, m1_timeout  (same as m0, for master 1)
flash_mem_read  out  1  read command to flash
flash_mem_address  out  ADDR_W  latched owner address
flash_mem_byteenable  out  4  latched owner byteenable
flash_mem_waitrequest  in  1  flash stall
flash_mem_readdata  in  DATA_W  flash data
flash_mem_readdatavalid  in  1  flash data valid
owner  out  1  current/last granted master
busy  out  1  high in ISSUE or WAIT

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE and priority pointer is 0.
  - All outputs low/zero, except m0_waitrequest and m1_waitrequest, which are 1.
  - flash_mem_read drops immediately, with no clock edge required.
  - Reset mid-transaction abandons the read; no valid or timeout pulse is issued.
- State machine (registered): IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - One requester: it wins.
  - Both requesters: the master equal to the priority pointer wins.
  - On the edge: latch owner, address and byteenable; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - flash_mem_read=1 with the latched address and byteenable.
  - m<owner>_waitrequest = flash_mem_waitrequest (combinational); the other master's waitrequest stays 1.
  - When flash_mem_waitrequest=0, the command is accepted. Go to WAIT and clear the timeout counter.
  - flash_mem_readdatavalid in ISSUE is ignored.
- WAIT:
  - flash_mem_read=0. The counter increments each cycle.
  - On flash_mem_readdatavalid:
    - Register flash_mem_readdata into m<owner>_readdata.
    - Pulse m<owner>_readdatavalid on the next cycle for exactly 1 cycle.
    - Set the priority pointer to ~owner; go to IDLE.
  - If the counter reaches TIMEOUT-1 with no valid:
    - Pulse m<owner>_timeout for 1 cycle and leave m<owner>_readdata unchanged.
    - Set the priority pointer to ~owner; go to IDLE.
  - Readdatavalid and timeout in the same cycle: data wins, no timeout pulse.
- Stray flash_mem_readdatavalid in IDLE is dropped; no output pulse.
- Minimum transaction: 1 cycle IDLE grant, 1 cycle ISSUE (no stall), N cycles WAIT, valid visible one cycle after flash valid.
- Back-to-back: a new grant may occur in the IDLE cycle right after completion. The readdatavalid pulse of the previous read coincides with that cycle.
- The non-owner's read is held pending and never lost; its waitrequest stays 1 until it is served.
- readdata registers hold their value between reads.
- owner holds the last granted master.

Test Plan:
- Single read: m0_read=1, addr 0x000123; flash waitrequest low, readdatavalid 3 cycles later with 0xDEADBEEF -> flash_mem_address=0x000123, m0_waitrequest low for exactly 1 cycle, m0_readdata=0xDEADBEEF, m0_readdatavalid 1-cycle pulse, m1 outputs untouched.
- Contention: m0 and m1 request continuously (addr 0x10 / 0x20) after reset -> flash address sequence 0x10, 0x20, 0x10, 0x20; each master gets data only for its own address.
- Stall: flash_mem_waitrequest high 5 cycles in ISSUE -> flash_mem_read and address stable for 6 cycles, owner waitrequest low only in the accepting cycle.
- Timeout: TIMEOUT=8, no readdatavalid -> m1_timeout pulses 8 cycles after acceptance, busy drops. A later stray readdatavalid produces no m0/m1 valid.
- Reset mid-WAIT: rst_n low for 2 cycles while owner=1 -> flash_mem_read=0 and both waitrequests=1 immediately, no pulses. After release, m0 wins a simultaneous request.
- Same-cycle valid and timeout at count TIMEOUT-1 -> readdatavalid pulse delivered, m<owner>_timeout stays 0.
